simple_mem_responder: RTL and testbench

//   Memory-side responder for the memory-access stage of the SIMPLE pipeline.
//   It serves the stage's address, storeData, rden and wren requests from an internal word array,
//   one word-mapped output port and one word-mapped input port.

---
 rtl/simple_mem_responder_if.sv | 23 ++
 rtl/simple_mem_responder.sv | 109 ++++++++++
 tb/tb_simple_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_mem_responder_if.sv
// Bus between the SIMPLE memory-access stage and its memory responder.
// The stage side drives requests and the external input port; the responder drives the rest.
interface simple_mem_responder_if;
  logic [15:0] address;
  logic [15:0] data;
  logic        rden;
  logic        wren;
  logic [15:0] q;
  logic        ready;
  logic [15:0] ioOut;
  logic [15:0] ioIn;
  logic        fault;

  modport master (
    output address, data, rden, wren, ioIn,
    input  q, ready, ioOut, fault
  );

  modport slave (
    input  address, data, rden, wren, ioIn,
    output q, ready, ioOut, fault
  );
endinterface

// File: rtl/simple_mem_responder.sv
// Memory responder for the SIMPLE pipeline: a word array cleared by a post-reset sweep,
// one memory-mapped I/O word, registered read data and a sticky out-of-range fault.
module simple_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [15:0] IO_ADDR    = 16'hFFFF,
  parameter logic [15:0] INIT_VALUE = 16'h0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  simple_mem_responder_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,    ptr_d;
  logic [15:0]           q_q,      q_d;
  logic [15:0]           io_out_q, io_out_d;
  logic                  ready_q,  ready_d;
  logic                  fault_q,  fault_d;

  logic [15:0]           mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [15:0]           mem_wdata;

  logic                  io_hit;
  logic                  arr_hit;
  logic [ADDR_WIDTH-1:0] index;

  assign io_hit  = (bus.address == IO_ADDR);
  assign arr_hit = ((bus.address >> ADDR_WIDTH) == 16'h0000) && !io_hit;
  assign index   = bus.address[ADDR_WIDTH-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    q_d       = q_q;
    io_out_d  = io_out_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = INIT_VALUE;

    unique case (state_q)
      ST_INIT: begin
        // Requests are ignored while the sweep owns the write port.
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (io_hit) begin
          if (bus.wren) io_out_d = bus.data;
          if (bus.rden) q_d      = bus.ioIn;
        end else if (arr_hit) begin
          // Read sees the pre-write contents because the array updates on the same edge.
          if (bus.rden) q_d = mem_q[index];
          mem_we    = bus.wren;
          mem_waddr = index;
          mem_wdata = bus.data;
        end else begin
          if (bus.rden) q_d = 16'h0000;
          if (bus.rden || bus.wren) fault_d = 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      q_q      <= 16'h0000;
      io_out_q <= 16'h0000;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      q_q      <= q_d;
      io_out_q <= io_out_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  // NOTE: the array has no reset branch; clearing it is the sweep's job, which keeps it RAM-mappable.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.q     = q_q;
  assign bus.ready = ready_q;
  assign bus.ioOut = io_out_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_simple_mem_responder.sv
// Randomized bench for simple_mem_responder against a behavioural model of the
// sweep timing, address map, read-before-write ordering and sticky fault.
module tb_simple_mem_responder;

  localparam int          DEPTH   = 4096;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam logic [15:0] INIT_V  = 16'h0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  simple_mem_responder_if bus ();

  simple_mem_responder #(
    .ADDR_WIDTH (12),
    .IO_ADDR    (IO_ADDR),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] ref_q;
  logic [15:0] ref_io;
  logic        ref_fault;
  logic        ref_run;
  int          ref_cnt;

  // Apply one request for one clock edge and advance the model by the same edge.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] dat);
    bus.rden    = rd;
    bus.wren    = wr;
    bus.address = addr;
    bus.data    = dat;
    @(posedge clock);
    if (!reset_n) begin
      ref_q = 16'h0000; ref_io = 16'h0000; ref_fault = 1'b0; ref_run = 1'b0; ref_cnt = 0;
    end else if (!ref_run) begin
      ref_cnt++;
      if (ref_cnt == DEPTH) begin
        ref_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_V;
      end
    end else if (addr == IO_ADDR) begin
      if (wr) ref_io = dat;
      if (rd) ref_q  = bus.ioIn;
    end else if (int'(addr) < DEPTH) begin
      if (rd) ref_q = ref_mem[addr];
      if (wr) ref_mem[addr] = dat;
    end else begin
      if (rd) ref_q = 16'h0000;
      if (rd || wr) ref_fault = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    int early;
    int init_side;
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 16'h2000, 16'h1111);
    total += 4;
    if (bus.q !== 16'h0000)     begin bad++; $display("FAIL reset_q got=%h want=0000", bus.q); end
    if (bus.ready !== 1'b0)     begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
    if (bus.ioOut !== 16'h0000) begin bad++; $display("FAIL reset_ioOut got=%h want=0000", bus.ioOut); end
    if (bus.fault !== 1'b0)     begin bad++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
    reset_n = 1'b1;
    early = 0;
    init_side = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i > DEPTH - 20)
        drive(1'b1, 1'b1, (i % 2 == 0) ? 16'h0000 : 16'h2000, 16'h7777);
      else
        drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      if (i < DEPTH && bus.ready !== 1'b0) early++;
      if (bus.q !== 16'h0000 || bus.fault !== 1'b0 || bus.ioOut !== 16'h0000) init_side++;
    end
    total += 3;
    if (early != 0)         begin bad++; $display("FAIL sweep_early_ready edges=%0d want=0", early); end
    if (bus.ready !== 1'b1) begin bad++; $display("FAIL sweep_ready_at_depth got=%b want=1", bus.ready); end
    if (init_side != 0)     begin bad++; $display("FAIL init_requests_ignored edges=%0d want=0", init_side); end
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    total++;
    if (bus.q !== INIT_V) begin bad++; $display("FAIL init_write_blocked got=%h want=%h", bus.q, INIT_V); end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 16'h0010, 16'h1234);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    total++;
    if (bus.q !== 16'h1234) begin bad++; $display("FAIL write_read got=%h want=1234", bus.q); end
    idle();
    total++;
    if (bus.q !== 16'h1234) begin bad++; $display("FAIL q_hold got=%h want=1234", bus.q); end
  endtask

  task automatic test_read_before_write();
    drive(1'b0, 1'b1, 16'h0005, 16'hAAAA);
    drive(1'b1, 1'b1, 16'h0005, 16'h5555);
    total++;
    if (bus.q !== 16'hAAAA) begin bad++; $display("FAIL rbw_old got=%h want=aaaa", bus.q); end
    drive(1'b1, 1'b0, 16'h0005, 16'h0000);
    total++;
    if (bus.q !== 16'h5555) begin bad++; $display("FAIL rbw_new got=%h want=5555", bus.q); end
  endtask

  task automatic test_io();
    drive(1'b0, 1'b1, IO_ADDR, 16'h00FF);
    total++;
    if (bus.ioOut !== 16'h00FF) begin bad++; $display("FAIL io_write got=%h want=00ff", bus.ioOut); end
    bus.ioIn = 16'hBEEF;
    drive(1'b1, 1'b0, IO_ADDR, 16'h0000);
    bus.ioIn = 16'h0000;
    total += 2;
    if (bus.q !== 16'hBEEF)     begin bad++; $display("FAIL io_read got=%h want=beef", bus.q); end
    if (bus.ioOut !== 16'h00FF) begin bad++; $display("FAIL io_read_keeps_out got=%h want=00ff", bus.ioOut); end
    bus.ioIn = 16'h3C3C;
    drive(1'b1, 1'b1, IO_ADDR, 16'hA5A5);
    total += 3;
    if (bus.q !== 16'h3C3C)     begin bad++; $display("FAIL io_rw_q got=%h want=3c3c", bus.q); end
    if (bus.ioOut !== 16'hA5A5) begin bad++; $display("FAIL io_rw_out got=%h want=a5a5", bus.ioOut); end
    if (bus.fault !== 1'b0)     begin bad++; $display("FAIL io_no_fault got=%b want=0", bus.fault); end
  endtask

  task automatic test_random_traffic();
    logic [15:0] addr;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = IO_ADDR;
        1:       addr = 16'($urandom_range(DEPTH, 16'hFFFE));
        2:       addr = 16'(DEPTH - 1);
        default: addr = 16'($urandom_range(0, 31));
      endcase
      bus.ioIn = 16'($urandom);
      drive(1'($urandom), 1'($urandom), addr, 16'($urandom));
      total += 3;
      if (bus.q !== ref_q)         begin bad++; $display("FAIL rand_q n=%0d got=%h want=%h", n, bus.q, ref_q); end
      if (bus.ioOut !== ref_io)    begin bad++; $display("FAIL rand_ioOut n=%0d got=%h want=%h", n, bus.ioOut, ref_io); end
      if (bus.fault !== ref_fault) begin bad++; $display("FAIL rand_fault n=%0d got=%b want=%b", n, bus.fault, ref_fault); end
    end
  endtask

  task automatic test_fault();
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle();
    drive(1'b0, 1'b1, 16'h0003, 16'h4242);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    total += 2;
    if (bus.q !== 16'h4242) begin bad++; $display("FAIL pre_fault_read got=%h want=4242", bus.q); end
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL pre_fault got=%b want=0", bus.fault); end
    drive(1'b1, 1'b0, 16'h2000, 16'h0000);
    total += 2;
    if (bus.q !== 16'h0000) begin bad++; $display("FAIL oob_read_q got=%h want=0000", bus.q); end
    if (bus.fault !== 1'b1) begin bad++; $display("FAIL oob_fault got=%b want=1", bus.fault); end
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    idle();
    total += 2;
    if (bus.fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", bus.fault); end
    if (bus.q !== ref_q)    begin bad++; $display("FAIL post_fault_read got=%h want=%h", bus.q, ref_q); end
  endtask

  task automatic test_sweep_clears();
    int miss;
    drive(1'b0, 1'b1, 16'h0000, 16'hDEAD);
    drive(1'b0, 1'b1, 16'(DEPTH - 1), 16'hDEAD);
    for (int n = 0; n < 64; n++) drive(1'b0, 1'b1, 16'($urandom_range(0, DEPTH - 1)), 16'hDEAD);
    reset_n = 1'b0;
    idle();
    total++;
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL fault_cleared got=%b want=0", bus.fault); end
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle();
    miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 16'(i), 16'h0000);
      if (bus.q !== ref_q) begin
        miss++;
        if (miss <= 4) $display("FAIL sweep_word addr=%0d got=%h want=%h", i, bus.q, ref_q);
      end
    end
    total++;
    if (miss != 0) bad++;
  endtask

  task automatic test_mid_sweep_reset();
    int early;
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    for (int i = 1; i < 100; i++) idle();
    reset_n = 1'b0;
    idle();
    total++;
    if (bus.ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b want=0", bus.ready); end
    reset_n = 1'b1;
    early = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      idle();
      if (i < DEPTH && bus.ready !== 1'b0) early++;
    end
    total += 2;
    if (early != 0)         begin bad++; $display("FAIL mid_restart_early edges=%0d want=0", early); end
    if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_restart_ready got=%b want=1", bus.ready); end
    drive(1'b1, 1'b0, 16'(DEPTH - 1), 16'h0000);
    total++;
    if (bus.q !== INIT_V) begin bad++; $display("FAIL mid_restart_word got=%h want=%h", bus.q, INIT_V); end
  endtask

  initial begin
    bus.address = 16'h0000;
    bus.data    = 16'h0000;
    bus.rden    = 1'b0;
    bus.wren    = 1'b0;
    bus.ioIn    = 16'h0000;
    ref_q = 16'h0000; ref_io = 16'h0000; ref_fault = 1'b0; ref_run = 1'b0; ref_cnt = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'hxxxx;
    test_reset();
    test_write_read();
    test_read_before_write();
    test_io();
    test_random_traffic();
    test_fault();
    test_sweep_clears();
    test_mid_sweep_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
